// File: rtl/zld_xca.sv
// zld_xca: zero run-length decoder.
// Expands 4-bit tokens into 3-bit samples. A literal token (bit 3 = 0) emits
// its low three bits as one sample; a run token (bit 3 = 1) emits
// count+1 zeros (1..8). Both sides use a data/valid/back-pressure handshake.
// Ports:
//   clock, reset   - system clock, synchronous active-high reset
//   i_d, i_v, i_b  - token in, token valid, back-pressure to the producer
//   o_d, o_v, o_b  - registered sample out, sample valid, back-pressure from the consumer
module zld_xca (
   input  logic       clock,
   input  logic       reset,
   input  logic [3:0] i_d,
   input  logic       i_v,
   output logic       i_b,
   output logic [2:0] o_d,
   output logic       o_v,
   input  logic       o_b
);

   localparam int unsigned SAMPLE_W = 3;

   typedef enum logic {
      PASS = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t              state;
   logic [SAMPLE_W-1:0] cnt;
   logic                drain;
   logic                take;

   // Only PASS accepts tokens, and only while the output register is empty or emptying.
   always_comb begin
      i_b = 1'b1;
      if (!reset && state == PASS) begin
         i_b = o_v & o_b;
      end
   end

   assign drain = o_v & ~o_b;
   assign take  = i_v & ~i_b;

   // Output register, remaining-zero counter and state.
   always_ff @(posedge clock) begin
      if (reset) begin
         state <= PASS;
         cnt   <= '0;
         o_d   <= '0;
         o_v   <= 1'b0;
      end else begin
         case (state)
            PASS: begin
               if (take) begin
                  o_v <= 1'b1;
                  if (!i_d[3]) begin
                     o_d <= i_d[SAMPLE_W-1:0];
                  end else begin
                     // First zero goes out now; cnt holds the zeros still owed.
                     o_d <= '0;
                     cnt <= i_d[SAMPLE_W-1:0];
                     if (i_d[SAMPLE_W-1:0] != '0) begin
                        state <= RUN;
                     end
                  end
               end else if (drain) begin
                  o_v <= 1'b0;
               end
            end
            RUN: begin
               if (drain) begin
                  o_d <= '0;
                  cnt <= cnt - SAMPLE_W'(1);
                  // Last zero of the run is loaded on this edge.
                  if (cnt == SAMPLE_W'(1)) begin
                     state <= PASS;
                  end
               end
            end
            default: state <= PASS;
         endcase
      end
   end

endmodule

// File: doc/zld_xca.md
# zld_xcA

Zero run-length decoder: the stage directly downstream of the zero run-length encoder, and its inverse. It consumes 4-bit encoded tokens and expands each one back into 3-bit samples: literal tokens produce one sample, run tokens produce a run of zeros. It connects to the encoder output through the team's standard data/valid/back-pressure stream handshake on both sides. Output is registered, and sustained throughput is one sample per clock.

## Interface
Parameters:
- none. Widths are fixed: 4-bit token in, 3-bit sample out, 3-bit run count.

Ports:
- clock  in  1  single system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset, sampled on rising edge of clock
- i_d  in  4  input token; i_d[3]=0 means literal, sample = i_d[2:0]; i_d[3]=1 means run of i_d[2:0]+1 zeros (1..8)
- i_v  in  1  input token valid
- i_b  out  1  input back-pressure; token transfers on a clock edge where i_v=1 and i_b=0
- o_d  out  3  output sample (registered)
- o_v  out  1  output sample valid (registered)
- o_b  in  1  output back-pressure from consumer; sample transfers on an edge where o_v=1 and o_b=0

## Operation
- Storage:
  - one-entry output register (o_d, o_v)
  - 3-bit remaining-zero counter cnt
  - FSM with states PASS and RUN
- drain = o_v & ~o_b. take = i_v & ~i_b.
- i_b is combinational:
  - PASS: i_b = o_v & o_b (accept whenever the register is empty or draining this cycle).
  - RUN: i_b = 1.
  - i_b = 1 while reset is asserted.
- PASS state:
  - take with literal: o_d <= i_d[2:0], o_v <= 1, stay PASS.
  - take with run of count field c: o_d <= 0, o_v <= 1, cnt <= c. Go to RUN if c != 0, else stay PASS.
  - drain with no take: o_v <= 0.
  - neither drain nor take: hold.
- RUN state:
  - drain: o_d <= 0, o_v stays 1, cnt <= cnt-1. If cnt-1 == 0, go to PASS; the last zero of the run is then in the register.
  - no drain: hold everything.
- Literal token 0x0 (literal value 0) is legal and emits exactly one zero. The encoder never produces it, but the decoder must not treat it specially.
- cnt never underflows; RUN is entered only with cnt >= 1.
- Reset (synchronous, takes effect at the edge):
  - o_v=0, o_d=0, cnt=0, state=PASS.
  - Any partially expanded run or undelivered sample is discarded.

## Timing
- Latency: token taken at edge k gives its first sample on o_d/o_v after edge k, visible in cycle k+1.
- Throughput: one sample per cycle when o_b=0.
  - Back-to-back literals are accepted every cycle.
  - A run token with field c occupies the input for c+1 output cycles; i_b=1 for c cycles after acceptance.
- Simultaneous drain and take in PASS: the register reloads with the new token at the same edge, with no bubble.
- o_b=1 stalls: o_d, o_v, cnt and state are all frozen; o_d must not change while o_v=1 and o_b=1.
- i_b depends combinationally on o_b (one gate level); no combinational path from i_v or i_d to any output.
- Reset has priority over take/drain in the same cycle. After reset deasserts, i_b=0 in the first cycle.
- Max run field 7 gives 8 zeros; cnt never exceeds 7.

## Test plan
- Reset then literals: after reset o_v=0, i_b=0. Drive tokens 0x3, 0x5, 0x7 on consecutive cycles with o_b=0 -> o_d = 3, 5, 7 with o_v=1 on cycles 1-3 after the first take; i_b stays 0.
- Run expansion: token 0xA (run, c=2) then literal 0x6 -> o_d = 0,0,0,6. i_b=1 for exactly 2 cycles after 0xA is taken; 0x6 is taken the cycle the last zero is presented.
- Max run and single run: token 0xF -> exactly 8 zeros. Token 0x8 -> exactly 1 zero with no RUN entry, and i_b stays 0.
- Back-pressure mid-run: token 0xB (4 zeros) with o_b=1 asserted for 3 cycles after the second zero appears -> o_d/o_v/cnt hold. Exactly 4 zeros total are delivered, and i_b=1 throughout the stall.
- Reset mid-run: token 0xF, reset asserted after 3 zeros are delivered -> next cycle o_v=0, i_b=0. A following literal 0x2 outputs 2, with no leftover zeros.
- Round-trip: random 3-bit stream through the encoder into this block, with random i_v and o_b -> output sequence equals the encoder input sequence exactly.
